// File: rtl/serial_link_phy_clk_cfg.sv
// Run-time TX clock configuration controller for the serial link PHY.
// New divider/shift settings are swapped in only after the stream is drained and the PHY has idled.
module serial_link_phy_clk_cfg #(
  parameter int unsigned MaxClkDiv         = 32,
  parameter int unsigned DefaultClkDiv     = 8,
  parameter int unsigned DefaultShiftStart = 2,
  parameter int unsigned DefaultShiftEnd   = 6,
  parameter int unsigned SettleCycles      = 4,
  parameter int unsigned CfgW              = $clog2(MaxClkDiv) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CfgW-1:0] cfg_clk_div_i,
  input  logic [CfgW-1:0] cfg_shift_start_i,
  input  logic [CfgW-1:0] cfg_shift_end_i,
  input  logic            cfg_update_i,
  input  logic            up_valid_i,
  output logic            up_ready_o,
  output logic            phy_valid_o,
  input  logic            phy_ready_i,
  output logic [CfgW-1:0] clk_div_o,
  output logic [CfgW-1:0] clk_shift_start_o,
  output logic [CfgW-1:0] clk_shift_end_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            cfg_err_o
);

  localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SettleCycles - 1);

  if ((DefaultClkDiv < 2) || (DefaultClkDiv > MaxClkDiv)) begin : g_bad_default_div
    $error("DefaultClkDiv out of range");
  end
  if ((DefaultShiftStart >= DefaultClkDiv) || (DefaultShiftEnd >= DefaultClkDiv) ||
      (DefaultShiftStart == DefaultShiftEnd)) begin : g_bad_default_shift
    $error("Default shifts must be distinct and below DefaultClkDiv");
  end
  if (SettleCycles < 1) begin : g_bad_settle
    $error("SettleCycles must be at least 1");
  end

  typedef enum logic [1:0] {RUN, DRAIN, SETTLE, APPLY} state_t;

  state_t          state_reg;
  logic [CntW-1:0] settle_cnt_reg;
  logic [CfgW-1:0] div_reg, start_reg, end_reg;
  logic [CfgW-1:0] shadow_div_reg, shadow_start_reg, shadow_end_reg;
  logic            busy_reg, done_reg, err_reg;
  logic            req_ok;
  logic            pass_through;

  assign req_ok = (cfg_clk_div_i >= CfgW'(2)) &&
                  (cfg_clk_div_i <= CfgW'(MaxClkDiv)) &&
                  (cfg_shift_start_i < cfg_clk_div_i) &&
                  (cfg_shift_end_i < cfg_clk_div_i) &&
                  (cfg_shift_start_i != cfg_shift_end_i);

  // The in-flight beat may still complete while draining; afterwards the PHY sees idle.
  assign pass_through = (state_reg == RUN) || (state_reg == DRAIN);
  assign phy_valid_o  = pass_through & up_valid_i;
  assign up_ready_o   = pass_through & phy_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= RUN;
      settle_cnt_reg   <= '0;
      div_reg          <= CfgW'(DefaultClkDiv);
      start_reg        <= CfgW'(DefaultShiftStart);
      end_reg          <= CfgW'(DefaultShiftEnd);
      shadow_div_reg   <= CfgW'(DefaultClkDiv);
      shadow_start_reg <= CfgW'(DefaultShiftStart);
      shadow_end_reg   <= CfgW'(DefaultShiftEnd);
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (cfg_update_i) begin
            if (req_ok) begin
              shadow_div_reg   <= cfg_clk_div_i;
              shadow_start_reg <= cfg_shift_start_i;
              shadow_end_reg   <= cfg_shift_end_i;
              err_reg          <= 1'b0;
              busy_reg         <= 1'b1;
              state_reg        <= DRAIN;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Drained once the beat transfers or upstream withdraws it.
          if (!up_valid_i || phy_ready_i) begin
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == CntLast) begin
            settle_cnt_reg <= '0;
            state_reg      <= APPLY;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + CntW'(1);
          end
        end
        APPLY: begin
          div_reg   <= shadow_div_reg;
          start_reg <= shadow_start_reg;
          end_reg   <= shadow_end_reg;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign clk_div_o         = div_reg;
  assign clk_shift_start_o = start_reg;
  assign clk_shift_end_o   = end_reg;
  assign busy_o            = busy_reg;
  assign done_o            = done_reg;
  assign cfg_err_o         = err_reg;

endmodule

// File: tb/tb_serial_link_phy_clk_cfg.sv
// Bench for serial_link_phy_clk_cfg: accepted configs are queued and compared when done_o pulses.
module tb_serial_link_phy_clk_cfg;

  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] s;
    logic [W-1:0] e;
  } cfg_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] cfg_div = '0, cfg_start = '0, cfg_end = '0;
  logic         cfg_update = 1'b0;
  logic         up_valid = 1'b0, phy_ready = 1'b0;
  logic         up_ready, phy_valid, busy, done, cfg_err;
  logic [W-1:0] clk_div, shift_start, shift_end;

  int   checks = 0;
  int   errors = 0;
  int   up_hs = 0;
  int   phy_hs = 0;
  cfg_t exp_q[$];
  cfg_t cur;

  always #5 clk = ~clk;

  serial_link_phy_clk_cfg dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_clk_div_i(cfg_div), .cfg_shift_start_i(cfg_start), .cfg_shift_end_i(cfg_end),
    .cfg_update_i(cfg_update),
    .up_valid_i(up_valid), .up_ready_o(up_ready),
    .phy_valid_o(phy_valid), .phy_ready_i(phy_ready),
    .clk_div_o(clk_div), .clk_shift_start_o(shift_start), .clk_shift_end_o(shift_end),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
  );

  // Scoreboard: every done_o pulse must apply the oldest accepted config.
  always @(negedge clk) begin
    if (rst_n) begin
      if (up_valid && up_ready) up_hs = up_hs + 1;
      if (phy_valid && phy_ready) phy_hs = phy_hs + 1;
      if (done) begin
        cfg_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL done_unexpected got cfg %0d/%0d/%0d required no done pulse",
                   clk_div, shift_start, shift_end);
        end else begin
          e = exp_q.pop_front();
          if ({clk_div, shift_start, shift_end} !== e) begin
            errors = errors + 1;
            $display("FAIL applied_cfg got %0d/%0d/%0d required %0d/%0d/%0d",
                     clk_div, shift_start, shift_end, e.d, e.s, e.e);
          end else begin
            $display("applied cfg %0d/%0d/%0d", clk_div, shift_start, shift_end);
          end
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int d, input int s, input int e);
    adv();
    cfg_div = W'(d); cfg_start = W'(s); cfg_end = W'(e); cfg_update = 1'b1;
    adv();
    cfg_update = 1'b0;
    $display("request div=%0d start=%0d end=%0d", d, s, e);
  endtask

  task automatic wait_idle(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_div, shift_start, shift_end} !== {6'd8, 6'd2, 6'd6}) begin
      errors++;
      $display("FAIL reset_cfg got %0d/%0d/%0d required 8/2/6", clk_div, shift_start, shift_end);
    end
    checks++;
    if ({busy, done, cfg_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy/done/err=%b required 000", {busy, done, cfg_err});
    end
    adv();
    rst_n = 1'b1;
    up_valid = 1'b1; phy_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({phy_valid, up_ready} !== 2'b10) begin
      errors++;
      $display("FAIL run_pass_a got valid/ready=%b required 10", {phy_valid, up_ready});
    end
    adv();
    phy_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({phy_valid, up_ready} !== 2'b11) begin
      errors++;
      $display("FAIL run_pass_b got valid/ready=%b required 11", {phy_valid, up_ready});
    end
    adv();
    up_valid = 1'b0; phy_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (phy_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_pass_c got phy_valid=%b required 0", phy_valid);
    end
    cur = '{d: 6'd8, s: 6'd2, e: 6'd6};
  endtask

  task automatic test_idle_update();
    int busy_cnt;
    int early;
    busy_cnt = 0;
    early = 0;
    request(4, 1, 3);
    exp_q.push_back('{d: 6'd4, s: 6'd1, e: 6'd3});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (clk_div !== cur.d || phy_valid !== 1'b0) early++;
    end
    checks++;
    if (busy_cnt != 6) begin
      errors++;
      $display("FAIL idle_busy_len got %0d required 6", busy_cnt);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL idle_early_change got %0d bad cycles required 0", early);
    end
    checks++;
    if ({done, cfg_err} !== 2'b10) begin
      errors++;
      $display("FAIL idle_done got done/err=%b required 10", {done, cfg_err});
    end
    cur = '{d: 6'd4, s: 6'd1, e: 6'd3};
  endtask

  task automatic test_traffic();
    int hs_busy;
    int low;
    int busy_cnt;
    hs_busy = 0; low = 0; busy_cnt = 0;
    up_hs = 0; phy_hs = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      up_valid = 1'b1;
      phy_ready = ((i % 8) == 7);
      cfg_update = (i == 11);
      if (i == 11) begin
        cfg_div = 6'd16; cfg_start = 6'd3; cfg_end = 6'd12;
        exp_q.push_back('{d: 6'd16, s: 6'd3, e: 6'd12});
        $display("request div=16 start=3 end=12 under traffic");
      end
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (phy_valid && phy_ready) hs_busy++;
        if (!phy_valid) low++;
      end
    end
    adv();
    up_valid = 1'b0; phy_ready = 1'b0; cfg_update = 1'b0;
    checks++;
    if (hs_busy != 1) begin
      errors++;
      $display("FAIL traffic_drain_hs got %0d required 1", hs_busy);
    end
    checks++;
    if (low != 5) begin
      errors++;
      $display("FAIL traffic_valid_low got %0d required 5", low);
    end
    checks++;
    if (busy_cnt != 9) begin
      errors++;
      $display("FAIL traffic_busy_len got %0d required 9", busy_cnt);
    end
    checks++;
    if (up_hs != 5 || phy_hs != 5) begin
      errors++;
      $display("FAIL traffic_beats got up=%0d phy=%0d required 5/5", up_hs, phy_hs);
    end
    cur = '{d: 6'd16, s: 6'd3, e: 6'd12};
  endtask

  task automatic test_invalid();
    int bad_d[4] = '{1, 33, 4, 4};
    int bad_s[4] = '{0, 1, 5, 2};
    int bad_e[4] = '{0, 2, 1, 2};
    int cyc;
    bit to;
    for (int k = 0; k < 4; k++) begin
      request(bad_d[k], bad_s[k], bad_e[k]);
      @(negedge clk);
      checks++;
      if ({cfg_err, busy} !== 2'b10) begin
        errors++;
        $display("FAIL invalid_%0d got err/busy=%b required 10", k, {cfg_err, busy});
      end
      checks++;
      if ({clk_div, shift_start, shift_end} !== cur) begin
        errors++;
        $display("FAIL invalid_cfg_%0d got %0d/%0d/%0d required %0d/%0d/%0d", k,
                 clk_div, shift_start, shift_end, cur.d, cur.s, cur.e);
      end
    end
    request(32, 31, 0);
    exp_q.push_back('{d: 6'd32, s: 6'd31, e: 6'd0});
    @(negedge clk);
    checks++;
    if ({cfg_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL valid_after_err got err/busy=%b required 01", {cfg_err, busy});
    end
    wait_idle(cyc, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL valid_after_err_timeout got busy=%b required 0", busy);
    end
    cur = '{d: 6'd32, s: 6'd31, e: 6'd0};
  endtask

  task automatic test_ignore_busy();
    int cyc;
    bit to;
    request(12, 4, 8);
    exp_q.push_back('{d: 6'd12, s: 6'd4, e: 6'd8});
    repeat (2) @(negedge clk);
    adv();
    cfg_div = 6'd20; cfg_start = 6'd1; cfg_end = 6'd2; cfg_update = 1'b1;
    adv();
    cfg_update = 1'b0;
    $display("request div=20 start=1 end=2 while busy");
    wait_idle(cyc, to);
    checks++;
    if (to || {clk_div, shift_start, shift_end} !== {6'd12, 6'd4, 6'd8} || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy got %0d/%0d/%0d err=%b required 12/4/8 err=0",
               clk_div, shift_start, shift_end, cfg_err);
    end
    adv();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_requeued got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    rises = 0;
    request(6, 1, 2);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_div, shift_start, shift_end} !== {6'd8, 6'd2, 6'd6} || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got %0d/%0d/%0d busy=%b required 8/2/6 busy=0",
               clk_div, shift_start, shift_end, busy);
    end
    adv();
    rst_n = 1'b1;
    up_valid = 1'b1; phy_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({phy_valid, up_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pass got valid/ready=%b required 11", {phy_valid, up_ready});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || !phy_valid) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL reset_mid_resume got %0d stalled cycles required 0", rises);
    end
    up_valid = 1'b0; phy_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_cfg got %0d queued required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle_update();
    test_traffic();
    test_invalid();
    test_ignore_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
